// File: rtl/tensor_assign_ctrl.sv
// Tensor assignment sequencer: scalar SET, FILL and strided COPY over an N-D view.
// The view is walked in row-major order; offsets are updated incrementally per element.
module tensor_assign_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int RANK   = 4,
    parameter int DIM_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [ADDR_W-1:0]       cmd_dst_base,
    input  logic [ADDR_W-1:0]       cmd_src_base,
    input  logic [RANK*DIM_W-1:0]   cmd_shape,
    input  logic [RANK*ADDR_W-1:0]  cmd_dst_stride,
    input  logic [RANK*ADDR_W-1:0]  cmd_src_stride,
    input  logic [RANK*DIM_W-1:0]   cmd_index,
    input  logic [DATA_W-1:0]       cmd_val,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    done,
    output logic                    err
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SET_CALC = 3'd1;
    localparam logic [2:0] SET_WR   = 3'd2;
    localparam logic [2:0] FILL_WR  = 3'd3;
    localparam logic [2:0] CP_RD    = 3'd4;
    localparam logic [2:0] CP_WR    = 3'd5;

    logic [2:0]        state;
    logic [DIM_W-1:0]  shape_q  [RANK];
    logic [DIM_W-1:0]  sidx_q   [RANK];
    logic [DIM_W-1:0]  idx_q    [RANK];
    logic [DIM_W-1:0]  nxt_idx  [RANK];
    logic [ADDR_W-1:0] dstr_q   [RANK];
    logic [ADDR_W-1:0] sstr_q   [RANK];
    logic [ADDR_W-1:0] dlvl_q   [RANK];
    logic [ADDR_W-1:0] slvl_q   [RANK];
    logic [ADDR_W-1:0] nxt_dlvl [RANK];
    logic [ADDR_W-1:0] nxt_slvl [RANK];
    logic [DATA_W-1:0] val_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wr_data;
    logic              done_q;
    logic              err_q;
    logic [RANK-1:0]   at_max;
    logic              last;
    logic              set_oob;
    logic [ADDR_W-1:0] set_off;
    logic              cmd_zero;
    logic              carry;
    int unsigned       pivot;
    logic [ADDR_W-1:0] dstep;
    logic [ADDR_W-1:0] sstep;

    always_comb begin
        set_oob  = 1'b0;
        cmd_zero = 1'b0;
        set_off  = dlvl_q[0];
        for (int unsigned d = 0; d < RANK; d++) begin
            at_max[d] = (idx_q[d] == shape_q[d] - 1'b1);
            if (sidx_q[d] >= shape_q[d]) set_oob = 1'b1;
            if (cmd_shape[d*DIM_W +: DIM_W] == '0) cmd_zero = 1'b1;
            set_off = set_off + ADDR_W'(sidx_q[d]) * dstr_q[d];
        end
        last = &at_max;
    end

    // Odometer step: pivot is the dim that increments; every inner dim restarts
    // from the pivot's new row start, so each level register holds its row base.
    always_comb begin
        carry = 1'b1;
        pivot = 0;
        for (int unsigned i = 0; i < RANK; i++) begin
            nxt_idx[RANK-1-i] = idx_q[RANK-1-i];
            if (carry) begin
                if (at_max[RANK-1-i]) begin
                    nxt_idx[RANK-1-i] = '0;
                end else begin
                    nxt_idx[RANK-1-i] = idx_q[RANK-1-i] + 1'b1;
                    carry = 1'b0;
                    pivot = RANK - 1 - i;
                end
            end
        end
        dstep = dlvl_q[pivot] + dstr_q[pivot];
        sstep = slvl_q[pivot] + sstr_q[pivot];
        for (int unsigned d = 0; d < RANK; d++) begin
            nxt_dlvl[d] = (d >= pivot) ? dstep : dlvl_q[d];
            nxt_slvl[d] = (d >= pivot) ? sstep : slvl_q[d];
        end
    end

    always_comb begin
        mem_en    = (state == SET_WR) || (state == FILL_WR) || (state == CP_RD) || (state == CP_WR);
        mem_we    = (state == SET_WR) || (state == FILL_WR) || (state == CP_WR);
        mem_addr  = '0;
        if (mem_we) mem_addr = dlvl_q[RANK-1];
        else if (state == CP_RD) mem_addr = slvl_q[RANK-1];
        wr_data   = (state == CP_WR) ? mem_rdata : val_q;
        mem_wdata = mem_we ? wr_data : wdata_q;
        done      = done_q || (state == SET_WR) || ((state == SET_CALC) && set_oob)
                    || (((state == FILL_WR) || (state == CP_WR)) && last);
        err       = err_q || ((state == SET_CALC) && set_oob);
        cmd_ready = (state == IDLE) && !done_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            val_q   <= '0;
            wdata_q <= '0;
            for (int unsigned d = 0; d < RANK; d++) begin
                shape_q[d] <= '0;
                sidx_q[d]  <= '0;
                idx_q[d]   <= '0;
                dstr_q[d]  <= '0;
                sstr_q[d]  <= '0;
                dlvl_q[d]  <= '0;
                slvl_q[d]  <= '0;
            end
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (mem_we) wdata_q <= mem_wdata;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        val_q <= cmd_val;
                        for (int unsigned d = 0; d < RANK; d++) begin
                            shape_q[d] <= cmd_shape[d*DIM_W +: DIM_W];
                            sidx_q[d]  <= cmd_index[d*DIM_W +: DIM_W];
                            dstr_q[d]  <= cmd_dst_stride[d*ADDR_W +: ADDR_W];
                            sstr_q[d]  <= cmd_src_stride[d*ADDR_W +: ADDR_W];
                            idx_q[d]   <= '0;
                            dlvl_q[d]  <= cmd_dst_base;
                            slvl_q[d]  <= cmd_src_base;
                        end
                        case (cmd_op)
                            2'd0: state <= SET_CALC;
                            2'd1: if (cmd_zero) done_q <= 1'b1; else state <= FILL_WR;
                            2'd2: if (cmd_zero) done_q <= 1'b1; else state <= CP_RD;
                            default: begin
                                done_q <= 1'b1;
                                err_q  <= 1'b1;
                            end
                        endcase
                    end
                end
                SET_CALC: begin
                    if (set_oob) begin
                        state <= IDLE;
                    end else begin
                        dlvl_q[RANK-1] <= set_off;
                        state          <= SET_WR;
                    end
                end
                SET_WR: state <= IDLE;
                FILL_WR: begin
                    if (last) begin
                        state <= IDLE;
                    end else begin
                        idx_q  <= nxt_idx;
                        dlvl_q <= nxt_dlvl;
                    end
                end
                CP_RD: state <= CP_WR;
                CP_WR: begin
                    if (last) begin
                        state <= IDLE;
                    end else begin
                        idx_q  <= nxt_idx;
                        dlvl_q <= nxt_dlvl;
                        slvl_q <= nxt_slvl;
                        state  <= CP_RD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
